// File: rtl/ifetch_queue_pkg.sv
// Shared front-end definitions: datapath widths, RV32 major opcodes used by
// decode, the fetch-queue entry layout and a PC alignment helper.
package ifetch_queue_pkg;

    localparam int XLEN   = 32;
    localparam int INST_W = 32;

    // Major opcodes (inst[6:0]) consumed by the decode control unit.
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_FLW    = 7'b0000111;
    localparam logic [6:0] OP_FSW    = 7'b0100111;

    // One decoded-side queue entry: the instruction word and where it came from.
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   pc;
    } ifq_entry_t;

    // Force a fetch address onto a word boundary.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] pc);
        return pc & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Parameterized synchronous FIFO with a synchronous flush. Storage is read
// combinationally from the head slot, so a word written on one edge becomes
// visible only after that edge (no write-to-read bypass).
module ifq_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);
    assign rdata   = mem[rd_ptr];

    // Storage, pointers and occupancy; flush empties without touching storage.
    // NOTE: state is updated with <= so every register samples pre-edge values;
    // the storage array is also reset so the head output reads zero in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues in-order fetches under a credit limit,
// tags each request with its PC, buffers returned words for decode, and on a
// redirect flushes everything and silently drops responses still in flight.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [INST_W-1:0] id_inst,
    output logic [XLEN-1:0]   id_pc,
    output logic [6:0]        id_opcode
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   tag_count;
    logic [CW-1:0]   occupancy;
    logic [CW:0]     credit_used;
    logic            tag_full;
    logic            entry_full;
    logic [XLEN-1:0] tag_pc;
    ifq_entry_t      entry_in;
    ifq_entry_t      entry_out;
    logic            req_fire;
    logic            rsp_retire;
    logic            rsp_keep;
    logic            pop_fire;

    // Every buffered word and every in-flight fetch holds one credit.
    assign credit_used    = {1'b0, occupancy} + {1'b0, outstanding};
    assign imem_req_valid = !rst && !redirect_valid && !tag_full && !entry_full
                            && (credit_used < CREDITS);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_retire = imem_rsp_valid && (outstanding != '0);
    assign rsp_keep   = rsp_retire && (discard == '0) && !redirect_valid
                        && (tag_count != '0);
    assign pop_fire   = id_valid && id_ready && !redirect_valid;
    assign entry_in   = '{inst: imem_rsp_data, pc: tag_pc};

    assign id_valid  = (occupancy != '0);
    assign id_inst   = entry_out.inst;
    assign id_pc     = entry_out.pc;
    assign id_opcode = entry_out.inst[6:0];

    // PC of every live request, consumed as its response returns.
    ifq_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (redirect_valid),
        .push  (req_fire),
        .wdata (fetch_pc),
        .pop   (rsp_keep),
        .rdata (tag_pc),
        .count (tag_count),
        .full  (tag_full)
    );

    // Instruction + PC entries waiting for decode.
    ifq_fifo #(
        .WIDTH ($bits(ifq_entry_t)),
        .DEPTH (DEPTH)
    ) u_entry_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (redirect_valid),
        .push  (rsp_keep),
        .wdata (entry_in),
        .pop   (pop_fire),
        .rdata (entry_out),
        .count (occupancy),
        .full  (entry_full)
    );

    // Outstanding count after this cycle's accept and retire.
    // NOTE: the default assignment first keeps this purely combinational (no latch).
    always_comb begin
        outstanding_next = outstanding;
        unique case ({req_fire, rsp_retire})
            2'b10:   outstanding_next = outstanding + CW'(1);
            2'b01:   outstanding_next = outstanding - CW'(1);
            default: outstanding_next = outstanding;
        endcase
    end

    // Fetch PC, in-flight count and the number of stale responses to drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                fetch_pc <= align_word(redirect_pc);
                discard  <= outstanding_next;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (rsp_retire && (discard != '0)) begin
                    discard <= discard - CW'(1);
                end
            end
        end
    end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries and maximum outstanding fetches (power of two, 2..8).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  instruction memory accepts request.
REQ-007 imem_req_addr  output  32  word-aligned fetch address.
REQ-008 imem_rsp_valid  input  1  response valid; responses return in request order, at least 1 cycle after acceptance.
REQ-009 imem_rsp_data  input  32  fetched instruction word.
REQ-010 redirect_valid  input  1  branch/jump/JALR taken; flush and refetch.
REQ-011 redirect_pc  input  32  new fetch address; bits [1:0] ignored.
REQ-012 id_valid  output  1  instruction available to decode.
REQ-013 id_ready  input  1  decode consumes the head entry.
REQ-014 id_inst  output  32  head instruction word.
REQ-015 id_pc  output  32  address of head instruction.
REQ-016 id_opcode  output  7  id_inst[6:0], feeds the decode control unit directly.

Function
REQ-017 Request accepted when imem_req_valid && imem_req_ready; fetch_pc then advances by 4 (32-bit wrap, no saturation).
REQ-018 imem_req_valid SHALL be high only when (occupancy + outstanding) < DEPTH and no redirect is present that cycle.
REQ-019 Outstanding counter: +1 on accept, -1 on response; both in same cycle leaves it unchanged.
REQ-020 Response that is not discarded SHALL be written to the tail with its PC, taken from a per-request PC FIFO of DEPTH entries.
REQ-021 Head pop on id_valid && id_ready; push and pop in the same cycle SHALL both take effect, occupancy unchanged.
REQ-022 id_valid = occupancy != 0; id_inst/id_pc/id_opcode held stable while id_valid && !id_ready.
REQ-023 Registered-read queue, no bypass: a response written in cycle N is visible on id_* no earlier than cycle N+1.
REQ-024 Redirect, cycle N: queue and PC FIFO emptied; fetch_pc <= {redirect_pc[31:2],2'b00}; discard counter <= outstanding after cycle-N updates; no request issued in cycle N.
REQ-025 Discard counter nonzero: each response decrements it and is dropped; a response arriving in cycle N itself counts as retired, not discarded.
REQ-026 Redirect overrides a simultaneous pop, push, or request; id_valid SHALL be 0 in cycle N+1.
REQ-027 Back-to-back redirects: each reloads fetch_pc and recomputes discard; last one wins.
REQ-028 Pointers wrap modulo DEPTH; full = occupancy == DEPTH, which the credit rule in REQ-018 makes unreachable with an overflowing push.
REQ-029 Response with outstanding == 0 is a protocol error; ignored, no state change.

Reset
REQ-030 On rst: fetch_pc=RESET_PC, occupancy=0, outstanding=0, discard=0, pointers=0.
REQ-031 Outputs in reset: imem_req_valid=0, id_valid=0, id_inst=0, id_pc=0, id_opcode=0.
REQ-032 Reset mid-transfer drops all in-flight state; the memory is reset by the same rst.
REQ-033 First request valid in the first cycle after rst deasserts, addr=RESET_PC.

Structure
REQ-034 Shared package holds XLEN=32, the INST_W constant, and opcode localparams (OP_RTYPE 0110011, OP_LOAD 0000011, OP_JALR 1100111, OP_BRANCH 1100011, OP_JAL 1101111, OP_FLW 0000111, OP_FSW 0100111), shared with decode.
REQ-035 One sub-module, ifq_fifo: a parameterized width/depth synchronous FIFO, instantiated twice (PC tags, instruction+PC entries).

Verification
REQ-036 Reset, imem ready=1, 1-cycle latency, id_ready=1 -> id_pc sequence 0x0,0x4,0x8 on consecutive cycles, one per cycle.
REQ-037 id_ready=0, memory always ready -> exactly 4 requests issued, imem_req_valid then low, id_pc 0x0 held; release -> 0x0..0xC in order.
REQ-038 3 outstanding, redirect to 0x100 -> next 3 responses dropped; first id_pc=0x100 with the inst returned for 0x100.
REQ-039 Redirect to 0x203 in the same cycle as a pop and a response -> fetch addr 0x200, id_valid=0 next cycle, old entries never emitted.
REQ-040 fetch_pc=0xFFFF_FFFC -> next request addr 0x0000_0000.
REQ-041 rst asserted with 2 outstanding -> all outputs 0 immediately; after release, first addr=RESET_PC, stale responses ignored.
